sub32_serial: RTL and testbench
===============================

SUB32_SERIAL -- requirements
Module: sub32_serial

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request pulse; operands are captured on the rising edge where start=1 and the block is ready.
REQ-005 a  input  WIDTH  minuend, sampled only on accepted start.
REQ-006 b  input  WIDTH  subtrahend, sampled only on accepted start.
REQ-007 busy  output  1  high while subtraction in progress (RUN).
REQ-008 done  output  1  single-cycle completion pulse.
REQ-009 d  output  WIDTH  registered difference a-b mod 2^WIDTH.
REQ-010 borrow  output  1  registered; 1 iff a<b unsigned.
REQ-011 zero  output  1  registered; 1 iff d==0.
REQ-012 ovf  output  1  registered signed overflow: (a[MSB]^b[MSB]) & (d[MSB]^a[MSB]).

Function
REQ-013 The block shall be a bit-serial subtractor processing one bit per clock, LSB first, with a single 1-bit full-subtractor cell.
REQ-014 The block shall implement FSM states IDLE, RUN and DONE, with ready = (state==IDLE or state==DONE).
REQ-015 On an edge with start=1 and ready, the block shall capture a and b into shift registers, clear the internal borrow bit and bit counter, and enter RUN.
REQ-016 start while in RUN shall be ignored, with no effect on operands, counter or outputs.
REQ-017 Each RUN edge shall compute bit k as dk = ak^bk^br and br' = (~ak&bk) | (~(ak^bk)&br), shift the operands right, and shift dk into the result MSB.
REQ-018 After the edge that processes bit WIDTH-1, the block shall load d, borrow (=final br), zero and ovf simultaneously, and enter DONE with done=1.
REQ-019 Latency shall be fixed: start accepted at edge T, done=1 during the cycle after edge T+WIDTH (32 cycles for the default), independent of operand values.
REQ-020 done shall be high exactly one cycle (the DONE state); DONE shall return to IDLE, or to RUN if start=1 on that edge (back-to-back, no bubble).
REQ-021 busy shall be 1 exactly in RUN.
REQ-022 d, borrow, zero and ovf shall change only at completion and hold their values through the next operation's RUN until its completion.
REQ-023 a and b shall be don't-care except on the accepted-start edge.

Reset
REQ-024 rst_n=0 shall immediately, without waiting for a clock, force IDLE; busy=0, done=0, d=0, borrow=0, zero=0, ovf=0; counter, shift registers and br cleared.
REQ-025 Reset asserted mid-RUN shall abort the operation with no done pulse and no output update.
REQ-026 After rst_n deasserts, the first rising edge with start=1 shall be accepted normally.

Verification
REQ-027 a=0x00000005, b=0x00000003, start pulse -> busy for 32 cycles, then done=1 one cycle; d=0x00000002, borrow=0, zero=0, ovf=0.
REQ-028 a=0x00000003, b=0x00000005 -> d=0xFFFFFFFE, borrow=1, zero=0, ovf=0.
REQ-029 a=0x80000000, b=0x00000001 -> d=0x7FFFFFFF, borrow=0, ovf=1; and a=b=0xDEADBEEF -> d=0, zero=1, borrow=0, ovf=0.
REQ-030 Start with a=10, b=4; at cycle 5 of RUN pulse start with a=1, b=2 -> ignored; result d=6. Then start again on the done cycle with a=0, b=1 -> accepted, next done 32 cycles later with d=0xFFFFFFFF, borrow=1.
REQ-031 Start with a=7, b=1; assert rst_n=0 at cycle 10 -> all outputs 0 immediately and no done pulse. Release rst_n, start with a=9, b=9 -> done after 32 cycles with d=0, zero=1.

Source files
------------

// File: rtl/sub32_serial.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first,
// WIDTH clocks per operation with registered flags.
module sub32_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] sd;
    logic             br;

    logic             ready;
    logic             accept;
    logic             last;
    logic             ak;
    logic             bk;
    logic             dk;
    logic             br_nx;
    logic [WIDTH-1:0] res;

    assign ready  = (state == IDLE) || (state == DONE);
    assign accept = start && ready;
    assign last   = (cnt == CW'(WIDTH - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // The single full-subtractor cell
    assign ak    = sa[0];
    assign bk    = sb[0];
    assign dk    = ak ^ bk ^ br;
    assign br_nx = (~ak & bk) | (~(ak ^ bk) & br);
    assign res   = {dk, sd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = accept ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = accept ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            d      <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            br  <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sd  <= {dk, sd[WIDTH-2:1]};
            br  <= br_nx;
            cnt <= cnt + CW'(1);
            // On the MSB step ak/bk/dk are the sign bits
            if (last) begin
                d      <= res;
                borrow <= br_nx;
                zero   <= (res == '0);
                ovf    <= (ak ^ bk) & (dk ^ ak);
            end
        end
    end

endmodule

// File: tb/tb_sub32_serial.sv
// Randomised scoreboard bench for sub32_serial against
// a plain-arithmetic reference model.
module tb_sub32_serial;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         borrow;
    logic         zero;
    logic         ovf;

    sub32_serial #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .d(d),
        .borrow(borrow),
        .zero(zero),
        .ovf(ovf)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         borrow;
        logic         zero;
        logic         ovf;
        int           when;
    } exp_t;

    exp_t q[$];
    exp_t last_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, int when);
        exp_t   e;
        longint sr;
        sr       = longint'($signed(x)) - longint'($signed(y));
        e.d      = x - y;
        e.borrow = (x < y);
        e.zero   = (x == y);
        e.ovf    = (sr > 64'sh7fffffff) || (sr < -64'sh80000000);
        e.when   = when;
        return e;
    endfunction

    function automatic exp_t zero_e();
        exp_t e;
        e.d      = '0;
        e.borrow = 1'b0;
        e.zero   = 1'b0;
        e.ovf    = 1'b0;
        e.when   = 0;
        return e;
    endfunction

    // Monitor: pop and compare on done, otherwise outputs must hold
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'd0);
                end else begin
                    last_e = q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(last_e.when));
                    chk("d", 64'(d), 64'(last_e.d));
                    chk("borrow", 64'(borrow), 64'(last_e.borrow));
                    chk("zero", 64'(zero), 64'(last_e.zero));
                    chk("ovf", 64'(ovf), 64'(last_e.ovf));
                end
            end else begin
                chk("hold", {29'd0, d, borrow, zero, ovf},
                    {29'd0, last_e.d, last_e.borrow, last_e.zero, last_e.ovf});
            end
            if (q.size() > 0)
                chk("busy", 64'(busy),
                    64'(cyc >= q[0].when - W && cyc < q[0].when));
            else
                chk("busy_idle", 64'(busy), 64'd0);
        end
    end

    // Drive at posedge+1; the next edge is the accepting one
    task automatic go(logic [W-1:0] x, logic [W-1:0] y, bit accepted);
        start = 1'b1;
        a     = x;
        b     = y;
        if (accepted) q.push_back(model(x, y, cyc + 1 + W));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < W + 4) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        last_e = zero_e();
        #3;
        chk("rst_outs", {28'd0, d, busy, done, borrow, zero, ovf}, 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        go(32'h5, 32'h3, 1);
        wait_done();
        idle(1);
        go(32'h3, 32'h5, 1);
        wait_done();
        idle(2);
        go(32'h8000_0000, 32'h1, 1);
        wait_done();
        idle(1);
        go(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        wait_done();
        idle(1);

        // start during RUN is ignored; back-to-back on done
        go(32'd10, 32'd4, 1);
        idle(4);
        go(32'd1, 32'd2, 0);
        wait_done();
        go(32'd0, 32'd1, 1);
        wait_done();
        idle(1);

        // reset mid-run aborts with no done
        go(32'd7, 32'd1, 1);
        idle(9);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", {28'd0, d, busy, done, borrow, zero, ovf}, 64'd0);
        q.delete();
        last_e = zero_e();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        go(32'd9, 32'd9, 1);
        wait_done();
        idle(1);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = $urandom;
            y = (i % 5 == 0) ? x : W'($urandom);
            if (i % 7 == 3) y = x + 1;
            go(x, y, 1);
            if ($urandom_range(0, 3) == 0) go($urandom, $urandom, 0);
            wait_done();
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
